// File: rtl/fp_align_add.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_align_add                                                    |
// | Purpose  : Two-stage align-and-add front half of the single-precision FP   |
// |            adder. Stage 1 unpacks, classifies and orders the operands by   |
// |            magnitude; stage 2 aligns the smaller mantissa (with sticky)    |
// |            and adds or subtracts it from the larger one.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fp_align_add #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int EXT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [EXP_W+FRAC_W:0]       A,
  input  logic [EXP_W+FRAC_W:0]       B,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [EXP_W+FRAC_W:0]       outA,
  output logic [EXP_W+FRAC_W:0]       outB,
  output logic                        signA,
  output logic                        signB,
  output logic                        ANaN,
  output logic                        BNaN,
  output logic                        Ainf,
  output logic                        Binf,
  output logic                        Azero,
  output logic                        Bzero,
  output logic                        alignedSign,
  output logic [EXP_W-1:0]            exponentOut,
  output logic [FRAC_W+EXT_W:0]       alignedResult,
  output logic                        carryOut
);

  localparam int WORD_W = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = 1 + FRAC_W;
  localparam int RES_W  = MANT_W + EXT_W;
  localparam int DIFF_W = 6;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              big_sign;
    logic              eff_sub;
    logic [EXP_W-1:0]  big_exp;
    logic [MANT_W-1:0] big_mant;
    logic [MANT_W-1:0] small_mant;
    logic [DIFF_W-1:0] diff;
  } s1_t;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [RES_W-1:0]  res;
    logic              carry;
  } s2_t;

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_adv, accept;

  // Handshake: a stage moves forward when the one after it is empty or moving.
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready && !flush;

  // Stage 1 datapath: unpack, classify, order by magnitude, exponent distance.
  logic [EXP_W-1:0]  exp_a, exp_b, eff_a, eff_b, exp_diff;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [MANT_W-1:0] mant_a, mant_b;
  logic              a_is_big;
  always_comb begin
    exp_a    = A[WORD_W-2:FRAC_W];
    exp_b    = B[WORD_W-2:FRAC_W];
    frac_a   = A[FRAC_W-1:0];
    frac_b   = B[FRAC_W-1:0];
    // Subnormals behave as exponent 1 with no hidden bit.
    eff_a    = (exp_a == '0) ? EXP_W'(1) : exp_a;
    eff_b    = (exp_b == '0) ? EXP_W'(1) : exp_b;
    mant_a   = {(exp_a != '0), frac_a};
    mant_b   = {(exp_b != '0), frac_b};
    a_is_big = {eff_a, mant_a} >= {eff_b, mant_b};
    exp_diff = a_is_big ? (eff_a - eff_b) : (eff_b - eff_a);

    s1_d = s1_q;
    if (accept) begin
      s1_d.a          = A;
      s1_d.b          = B;
      s1_d.a_nan      = (exp_a == '1) && (frac_a != '0);
      s1_d.b_nan      = (exp_b == '1) && (frac_b != '0);
      s1_d.a_inf      = (exp_a == '1) && (frac_a == '0);
      s1_d.b_inf      = (exp_b == '1) && (frac_b == '0);
      s1_d.a_zero     = (exp_a == '0) && (frac_a == '0);
      s1_d.b_zero     = (exp_b == '0) && (frac_b == '0);
      s1_d.big_sign   = a_is_big ? A[WORD_W-1] : B[WORD_W-1];
      s1_d.eff_sub    = A[WORD_W-1] ^ B[WORD_W-1];
      s1_d.big_exp    = a_is_big ? eff_a : eff_b;
      s1_d.big_mant   = a_is_big ? mant_a : mant_b;
      s1_d.small_mant = a_is_big ? mant_b : mant_a;
      // Any shift of RES_W or more leaves only sticky, so cap the distance there.
      s1_d.diff       = (exp_diff > EXP_W'(RES_W)) ? DIFF_W'(RES_W) : exp_diff[DIFF_W-1:0];
    end
  end

  // Stage 2 datapath: align smaller mantissa with sticky, then add/subtract.
  logic [2*RES_W-1:0] shift_wide;
  logic [RES_W-1:0]   big_ext, small_aligned, mag_diff;
  logic [RES_W:0]     mag_sum;
  logic               sticky;
  always_comb begin
    big_ext       = {s1_q.big_mant, {EXT_W{1'b0}}};
    // Low half of the wide shift collects every bit pushed past bit 0.
    shift_wide    = {s1_q.small_mant, {EXT_W{1'b0}}, {RES_W{1'b0}}} >> s1_q.diff;
    sticky        = |shift_wide[RES_W-1:0];
    small_aligned = {shift_wide[2*RES_W-1:RES_W+1], shift_wide[RES_W] | sticky};
    mag_sum       = {1'b0, big_ext} + {1'b0, small_aligned};
    mag_diff      = big_ext - small_aligned;

    s2_d = s2_q;
    if (s1_adv) begin
      s2_d.a      = s1_q.a;
      s2_d.b      = s1_q.b;
      s2_d.a_nan  = s1_q.a_nan;
      s2_d.b_nan  = s1_q.b_nan;
      s2_d.a_inf  = s1_q.a_inf;
      s2_d.b_inf  = s1_q.b_inf;
      s2_d.a_zero = s1_q.a_zero;
      s2_d.b_zero = s1_q.b_zero;
      s2_d.exp    = s1_q.big_exp;
      if (s1_q.eff_sub) begin
        s2_d.res   = mag_diff;
        s2_d.carry = 1'b0;
        // Exact cancellation yields +0.
        s2_d.sign  = (mag_diff == '0) ? 1'b0 : s1_q.big_sign;
      end else begin
        s2_d.res   = mag_sum[RES_W-1:0];
        s2_d.carry = mag_sum[RES_W];
        s2_d.sign  = s1_q.big_sign;
      end
    end
  end

  // Stage occupancy: flush wins over everything, then load/drain.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)         s1_valid_d = 1'b1;
      else if (s1_adv)    s1_valid_d = 1'b0;
      if (s1_adv)         s2_valid_d = 1'b1;
      else if (out_ready) s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign outA          = s2_q.a;
  assign outB          = s2_q.b;
  assign signA         = s2_q.a[WORD_W-1];
  assign signB         = s2_q.b[WORD_W-1];
  assign ANaN          = s2_q.a_nan;
  assign BNaN          = s2_q.b_nan;
  assign Ainf          = s2_q.a_inf;
  assign Binf          = s2_q.b_inf;
  assign Azero         = s2_q.a_zero;
  assign Bzero         = s2_q.b_zero;
  assign alignedSign   = s2_q.sign;
  assign exponentOut   = s2_q.exp;
  assign alignedResult = s2_q.res;
  assign carryOut      = s2_q.carry;

endmodule
`default_nettype wire

// File: doc/fp_align_add.md
Name: fp_align_add

Overview:
- Two-stage pipelined align-and-add stage for the single-precision FP adder; sits directly upstream of the normalize/round stage and drives its bus fields.
- Unpacks A and B, classifies special operands, orders them by magnitude, aligns the smaller mantissa with a sticky bit, then adds or subtracts.
- Produces the 32-bit extended magnitude, carry-out, sign and pre-normalization exponent.
- Uses a valid/ready handshake with full backpressure and a synchronous flush.

Parameters:
- EXP_W, 8, exponent field width. Only 8 is verified.
- FRAC_W, 23, fraction field width. Only 23 is verified.
- EXT_W, 8, extension bits below the fraction (guard/round/sticky region). alignedResult width is 1+FRAC_W+EXT_W = 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of both pipeline stages.
- in_valid  in  1  operand pair A/B is valid.
- in_ready  out  1  stage can accept an operand pair this cycle.
- A  in  32  IEEE-754 single operand A.
- B  in  32  IEEE-754 single operand B.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  downstream accepts the result.
- outA, outB  out  32 each  operands passed through unchanged (used for NaN/inf/zero forwarding).
- signA, signB  out  1 each  operand signs.
- ANaN, BNaN, Ainf, Binf, Azero, Bzero  out  1 each  classification flags.
- alignedSign  out  1  sign of the result.
- exponentOut  out  8  larger operand's effective exponent.
- alignedResult  out  32  extended magnitude: hidden bit at [31], fraction at [30:8], extension at [7:0].
- carryOut  out  1  bit 32 of the magnitude sum.

Behaviour:
- Reset (async, rst_n=0): both stage valid bits=0, all output registers=0, in_ready=1 once rst_n=1. Reset mid-operation discards in-flight data; no result appears after release.

Classification:
- NaN: exp=FF and frac≠0.
- inf: exp=FF and frac=0.
- zero: exp=0 and frac=0.
- Subnormal (exp=0, frac≠0): effective exponent 1, hidden bit 0. Normal operands: hidden bit 1.

Stage 1 (registered):
- Compare {effExp, mant24} of A and B; "big" is the larger, ties choose A.
- Register big/small sign, exponent and mantissa, effective-subtract (signA≠signB), all flags, and A/B.
- Register diff = expBig−expSmall, saturated to 32 (6 bits).

Stage 2 (registered):
- bigExt = {mantBig,8'b0}; smallExt = {mantSmall,8'b0}>>diff.
- Any 1 bit shifted out is ORed into bit 0. diff=32 gives smallExt = (mantSmall≠0).
- Add: {carryOut, alignedResult} = bigExt+smallExt.
- Subtract: alignedResult = bigExt−smallExt, carryOut=0.
- alignedSign = sign of big, except exact cancellation (result 0) gives sign 0.
- exponentOut = expBig (effective).
- Special-operand cases still flow through with flags set; magnitude fields are don't-care but deterministic.

Handshake and latency:
- Stage n advances when its successor is empty or advancing.
- in_ready = !s1_valid || s1_adv. out_valid = s2_valid. s2 holds while out_valid && !out_ready.
- Latency 2 cycles with out_ready=1; throughput 1/cycle; order preserved; no drops or duplicates.
- Output fields stay stable while out_valid=1 and out_ready=0.
- flush=1: both valid bits clear at the next edge. Flush has priority over in_valid in the same cycle, so that pair is not accepted. Data registers may keep stale values.
- Simultaneous accept and retire when full: allowed, and occupancy stays 2.

Test Plan:
- A=3F800000, B=3F800000, out_ready=1 -> out_valid 2 cycles later; carryOut=1, alignedResult=00000000, exponentOut=7F, alignedSign=0.
- A=3FC00000, B=BF800000 -> alignedResult=40000000, carryOut=0, exponentOut=7F, alignedSign=0.
- A=3F800000, B=2B800000 (diff 40, saturated to 32) -> alignedResult=80000001 (sticky), exponentOut=7F, carryOut=0.
- A=40490FDB, B=C0490FDB -> alignedResult=00000000, alignedSign=0, exponentOut=80. Also A=7F800000, B=FF800000 -> Ainf=Binf=1, signA=0, signB=1, outA/outB unchanged.
- Backpressure: out_ready=0, issue 3 pairs back-to-back -> two accepted, in_ready=0 on the third, first result stable. Raise out_ready -> results emerge in issue order, one per cycle.
- Assert flush with 2 entries in flight, then separately drop rst_n mid-transaction -> out_valid=0 next edge (flush) or immediately (reset). No ghost result afterwards; in_ready=1.
